// File: rtl/icache_axi_reader.sv
// I-cache refill engine: turns a one-line refill request into a single AXI4 INCR
// read burst, gathers the beats into a line buffer and hands the line back with rd_gnt.
module icache_axi_reader #(
    parameter logic [3:0] ARID  = 4'd0,
    parameter int         BEATS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_gnt,
    output logic [31:0] rd_data [0:BEATS-1],
    output logic        bus_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int              CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]   LAST_BEAT  = CW'(BEATS - 1);
    localparam logic [31:0]     ALIGN_MASK = ~32'(BEATS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          err_flag;
    logic          beat;
    logic          last_beat;
    logic          beat_err;

    assign arid    = ARID;
    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Handshake outputs are pure state decodes, so no AXI input reaches an output combinationally.
    assign arvalid = (state == ADDR);
    assign rready  = (state == DATA);
    assign rd_gnt  = (state == DONE);
    assign bus_err = (state == DONE) && err_flag;

    assign beat      = (state == DATA) && rvalid;
    assign last_beat = (cnt == LAST_BEAT);
    // A bad response, a missing rlast on the final beat, or an early rlast all flag the line.
    assign beat_err  = (rresp != 2'b00) || (last_beat != rlast);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (rd_req) state_nxt = ADDR;
            ADDR: if (arready) state_nxt = DATA;
            DATA: if (beat && (last_beat || rlast)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the line buffer is reset explicitly so an aborted burst never leaks stale words.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr   <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                rd_data[i] <= '0;
            end
        end else begin
            if (state == IDLE && rd_req) begin
                araddr   <= rd_addr & ALIGN_MASK;
                cnt      <= '0;
                err_flag <= 1'b0;
            end
            if (beat) begin
                rd_data[cnt] <= rdata;
                cnt          <= cnt + 1'b1;
                if (beat_err) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_reader.sv
// Directed bench for icache_axi_reader: an inline AXI slave drives each burst
// from a per-test vector, and every observation goes through check().
module tb_icache_axi_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic [31:0] rd_data [0:7];
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_line [0:7];

    icache_axi_reader #(.ARID(4'd0), .BEATS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .rd_data (rd_data),
        .bus_err (bus_err),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":arvalid"}, arvalid, 0);
        check({tag, ":rready"}, rready, 0);
        check({tag, ":rd_gnt"}, rd_gnt, 0);
        check({tag, ":bus_err"}, bus_err, 0);
        check({tag, ":araddr"}, araddr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s:rd_data%0d", tag, i), rd_data[i], 32'h0);
        end
    endtask

    // One refill. Cycle k is the clock period that ends at edge k; edge 0 samples rd_req.
    // gap_a/gap_b: beat index preceded by one idle rvalid cycle (-1 = none).
    // abort_at > 0: assert rst after that many beats and return.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] base,
                         input int ar_wait, input int gap_a, input int gap_b,
                         input int err_beat, input int rlast_beat, input int abort_at,
                         input bit hold_req, input int exp_gnt, input bit exp_err);
        int          cyc = 0;
        int          beat = 0;
        int          wait_left = ar_wait;
        int          ar_seen = 0;
        int          last_idx;
        bit          ar_acc = 0;
        bit          hs_pend = 0;
        bit          done = 0;
        bit          sent;
        bit          gap_a_used = 0;
        bit          gap_b_used = 0;
        logic [31:0] exp_addr;

        exp_addr = {addr[31:5], 5'b0};
        last_idx = (rlast_beat < 8) ? rlast_beat : 7;
        rd_req   = 1'b1;
        rd_addr  = addr;
        step();
        cyc = 1;
        while (!done && cyc < 80) begin
            sent    = 0;
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
            rdata   = 32'hDEAD_0000 + 32'(cyc);
            if (rd_gnt) begin
                check({tag, ":gnt_cycle"}, cyc, exp_gnt);
                check({tag, ":bus_err"}, bus_err, exp_err);
                check({tag, ":ar_cycles"}, ar_seen, ar_wait + 1);
                check({tag, ":beats"}, beat, last_idx + 1);
                rd_req = hold_req;
                done   = 1;
            end else begin
                if (hs_pend) begin
                    ar_acc  = 1;
                    hs_pend = 0;
                end
                if (arvalid) begin
                    ar_seen++;
                    check({tag, ":araddr"}, araddr, exp_addr);
                    check({tag, ":arlen"}, arlen, 8'd7);
                    if (wait_left > 0) begin
                        wait_left--;
                        rvalid = 1'b1;
                    end else begin
                        arready = 1'b1;
                        hs_pend = 1;
                    end
                end else if (ar_acc && beat <= last_idx) begin
                    check({tag, ":rready"}, rready, 1);
                    if (beat == gap_a && !gap_a_used) begin
                        gap_a_used = 1;
                    end else if (beat == gap_b && !gap_b_used) begin
                        gap_b_used = 1;
                    end else begin
                        rvalid = 1'b1;
                        rdata  = base + 32'(beat);
                        rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                        rlast  = (beat == rlast_beat);
                        sent   = 1;
                    end
                end
            end
            step();
            cyc++;
            if (sent) begin
                exp_line[beat] = base + 32'(beat);
                beat++;
                if (abort_at > 0 && beat == abort_at) begin
                    rvalid = 1'b0;
                    rd_req = 1'b0;
                    rst    = 1'b1;
                    step();
                    rst = 1'b0;
                    for (int i = 0; i < 8; i++) exp_line[i] = 32'h0;
                    check_reset_state({tag, ":abort"});
                    return;
                end
            end
        end
        check({tag, ":gnt_seen"}, done, 1);
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        // Cycle after rd_gnt: pulse gone, no new AR yet, line still valid.
        check({tag, ":gnt_pulse"}, rd_gnt, 0);
        check({tag, ":post_arvalid"}, arvalid, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s:word%0d", tag, i), rd_data[i], exp_line[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = 32'h0;
        arready = 1'b0;
        rdata   = 32'h0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        for (int i = 0; i < 8; i++) exp_line[i] = 32'h0;
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_state("reset");
        check("arid", arid, 4'd0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);

        fetch("zero_wait", 32'hBFC0_0014, 32'h1000_0000, 0, -1, -1, -1, 7, 0, 0, 10, 0);
        check("zero_wait:w0", rd_data[0], 32'h1000_0000);
        check("zero_wait:w7", rd_data[7], 32'h1000_0007);

        fetch("backpressure", 32'h0000_1008, 32'h5000_0000, 3, 3, 6, -1, 7, 0, 0, 15, 0);

        fetch("err_resp", 32'h0000_2010, 32'h2000_0000, 0, -1, -1, 4, 7, 0, 0, 10, 1);
        check("err_resp:w4", rd_data[4], 32'h2000_0004);

        fetch("early_last", 32'h0000_3000, 32'h6000_0000, 0, -1, -1, -1, 5, 0, 0, 8, 1);
        check("early_last:w5", rd_data[5], 32'h6000_0005);
        check("early_last:w6", rd_data[6], 32'h2000_0006);
        check("early_last:w7", rd_data[7], 32'h2000_0007);

        fetch("abort", 32'h0000_4000, 32'h7000_0000, 0, -1, -1, -1, 7, 3, 0, 0, 0);
        fetch("after_abort", 32'h8000_0040, 32'h3000_0000, 0, -1, -1, -1, 7, 0, 0, 10, 0);
        check("after_abort:w2", rd_data[2], 32'h3000_0002);

        fetch("b2b_first", 32'h0000_1234, 32'h9000_0000, 0, -1, -1, -1, 7, 0, 1, 10, 0);
        fetch("b2b_second", 32'h0000_5678, 32'hA000_0000, 0, -1, -1, -1, 7, 0, 0, 10, 0);
        check("b2b_second:araddr", araddr, 32'h0000_5660);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_axi_reader.md
# icache_axi_reader

Cache-line fetch engine on the memory side of the instruction cache's refill interface. It accepts a one-line refill request (`rd_req`/`rd_addr`) and issues a single 8-beat AXI4 INCR read burst. It collects the beats into a line buffer, then returns the whole line with a one-cycle `rd_gnt` pulse. It sits between the I-cache and the AXI interconnect and has exactly one transaction outstanding.

## Interface
- `ARID`, default 4'd0: constant AXI ID driven on `arid`.
- `BEATS`, default 8: words per line; `arlen` = BEATS-1; the line is aligned to BEATS*4 bytes (5 LSBs for 8).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_req`  in  1  refill request from cache; level, held until `rd_gnt`.
- `rd_addr`  in  32  miss address; any byte within the line.
- `rd_gnt`  out  1  one-cycle pulse: line available on `rd_data`.
- `rd_data[0:BEATS-1]`  out  32 each  line words, word i = byte offset 4*i.
- `bus_err`  out  1  pulses with `rd_gnt` if the burst had an error (see below).
- `arid`  out  4  = ARID.
- `araddr`  out  32  {rd_addr[31:5], 5'b0}, latched.
- `arlen`  out  8  = BEATS-1 (7).
- `arsize`  out  3  = 3'b010.
- `arburst`  out  2  = 2'b01 (INCR).
- `arvalid`  out  1  read-address valid.
- `arready`  in  1  read-address ready.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response.
- `rlast`  in  1  last beat.
- `rvalid`  in  1  read-data valid.
- `rready`  out  1  read-data ready.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if `rd_req`=1, latch the aligned address into `araddr`, clear the beat counter and the error flag, and go to ADDR.
- ADDR: `arvalid`=1. `araddr` stays stable until `arready`=1 at an edge, then go to DATA. `rready`=0; any `rvalid` seen here is ignored.
- DATA: `rready`=1. On each `rvalid` beat:
  - write `rdata` into `rd_data[cnt]`;
  - increment the 3-bit `cnt`;
  - set the error flag if `rresp`≠2'b00.
- Beat count and `rlast`:
  - The beat with `cnt`=BEATS-1 ends the burst and moves to DONE.
  - `rlast`=0 on that beat sets the error flag.
  - `rlast`=1 on an earlier beat also sets the error flag, then moves to DONE; unfilled words keep their old contents.
- DONE: `rd_gnt`=1 for exactly one cycle, `bus_err` = error flag, then go to IDLE.
- `rd_req` is sampled only in IDLE. A request still high in the cycle right after DONE starts a new fetch, which is legal but redundant.
- `rd_data` holds stable from the `rd_gnt` cycle until the first data beat of the next burst. The cache writes the line in the cycle after `rd_gnt`, so the data must remain valid there too.
- `arid`, `arlen`, `arsize`, `arburst` are constants.

## Timing
- Reset values:
  - state IDLE;
  - `arvalid`, `rready`, `rd_gnt`, `bus_err` = 0;
  - `araddr` = 0;
  - all `rd_data` words = 0;
  - `cnt` = 0.
- `rst` mid-burst aborts immediately to IDLE with the values above. The interconnect is reset by the same `rst`, so there is no orphan drain.
- All outputs are registered or decoded from the state; there is no combinational path from AXI inputs to outputs.
- Minimum latency, with `arready` and `rvalid` always 1:
  - `rd_req` seen at edge 0;
  - `arvalid` in cycle 1, handshake at edge 1;
  - beats at edges 2..9;
  - `rd_gnt` in cycle 10.
  - Each `arready`/`rvalid` wait cycle adds one cycle.
- One request at a time; no new AR is issued until DONE has passed.

## Test plan
- Zero-wait fetch: `rd_req`=1, `rd_addr`=0xBFC0_0014; slave returns 0x1000_0000+i with `rlast` on beat 7. Required: `araddr`=0xBFC0_0000, `arlen`=7, `rd_gnt` in cycle 10 only, `rd_data[i]`=0x1000_0000+i, `bus_err`=0.
- Backpressure: `arready` low for 3 cycles; `rvalid` gaps after beats 2 and 5. Required: `arvalid`/`araddr` stable until the handshake, beats in order, `rd_gnt` in cycle 15, data correct.
- Error response: `rresp`=2'b10 on beat 4. Required: all 8 words stored, `rd_gnt` and `bus_err` both 1 in the same cycle.
- Early `rlast` on beat 5. Required: DONE after beat 5, `bus_err`=1, words 6 and 7 unchanged from the previous line.
- Reset mid-burst after 3 beats, then a new request to 0x8000_0040. Required: all outputs return to reset values; the new burst produces the correct line with no stale words from the aborted burst.
- Back-to-back requests: `rd_req` high again in the cycle after `rd_gnt`. Required: previous `rd_data` stable through that cycle, and a second AR issued in the cycle after.
